// File: rtl/list_sum_pkg.sv
// Shared types for the list-sum arbiter slice.
// States and default widths used by the arbiter, its picker and interface.
package list_sum_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LAUNCH,
    WAIT,
    RELEASE
  } state_t;

endpackage

// File: rtl/list_sum_arbiter_if.sv
// Client and datapath signals of the list-sum arbiter.
// master: the arbiter; slave: clients plus datapath/controller.
interface list_sum_arbiter_if
  import list_sum_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  localparam int IDX_W = $clog2(NREQ);

  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] head_ptr;
  logic [NREQ-1:0]        ack;
  logic [NREQ-1:0]        err;
  logic [DATA_W-1:0]      result;
  logic                   busy;
  logic [IDX_W-1:0]       grant_id;
  logic                   dp_start;
  logic [ADDR_W-1:0]      dp_head;
  logic                   dp_done;
  logic [DATA_W-1:0]      dp_sum;
  logic                   dp_step;
  logic                   dp_abort;

  modport master (
    input  req, head_ptr, dp_done, dp_sum, dp_step,
    output ack, err, result, busy, grant_id,
    output dp_start, dp_head, dp_abort
  );

  modport slave (
    output req, head_ptr, dp_done, dp_sum, dp_step,
    input  ack, err, result, busy, grant_id,
    input  dp_start, dp_head, dp_abort
  );

endinterface

// File: rtl/list_sum_arbiter_rr_picker.sv
// Round-robin priority encoder: first set req bit at or after rr_ptr,
// wrapping modulo NREQ.
module rr_picker #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  function automatic logic [IDX_W-1:0] wrap(input int v);
    return IDX_W'(v % NREQ);
  endfunction

  // Scan from the far end so the nearest offset overwrites last.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[wrap(int'(rr_ptr) + k)]) begin
        valid = 1'b1;
        index = wrap(int'(rr_ptr) + k);
      end
    end
  end

endmodule

// File: rtl/list_sum_arbiter.sv
// Round-robin sharing of the list-sum datapath among NREQ requesters.
// Optional walk watchdog enabled by defining LIST_SUM_TIMEOUT_EN.
module list_sum_arbiter
  import list_sum_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_NODES = 255
) (
  input logic clk,
  input logic rst,
  list_sum_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NREQ);

  state_t state, state_n;

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  rr_n;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_vld;
  logic [IDX_W-1:0]  gid_q;
  logic [ADDR_W-1:0] head_q;
  logic [DATA_W-1:0] result_q;
  logic [NREQ-1:0]   ack_q;
  logic [NREQ-1:0]   grant_oh;
  logic              fin_ok;
  logic              fin_abort;
  logic              hit;

  rr_picker #(
    .NREQ (NREQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .req   (bus.req),
    .rr_ptr(rr_ptr),
    .valid (pick_vld),
    .index (pick_idx)
  );

  assign grant_oh = NREQ'(1) << gid_q;
  assign rr_n     = (gid_q == IDX_W'(NREQ - 1)) ? '0 : gid_q + 1'b1;

  always_comb begin
    state_n   = state;
    fin_ok    = 1'b0;
    fin_abort = 1'b0;
    unique case (state)
      IDLE:    if (|bus.req) state_n = ARB;
      ARB:     state_n = pick_vld ? LAUNCH : IDLE;
      LAUNCH:  state_n = WAIT;
      WAIT: begin
        if (bus.dp_done) begin
          fin_ok  = 1'b1;
          state_n = RELEASE;
        end else if (hit) begin
          fin_abort = 1'b1;
          state_n   = RELEASE;
        end
      end
      // Let the controller drop done before re-arbitrating.
      RELEASE: if (!bus.dp_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gid_q    <= '0;
      head_q   <= '0;
      result_q <= '0;
      ack_q    <= '0;
    end else begin
      state <= state_n;
      ack_q <= '0;
      if (state == ARB && pick_vld) begin
        gid_q  <= pick_idx;
        head_q <= bus.head_ptr[int'(pick_idx)*ADDR_W +: ADDR_W];
      end
      if (fin_ok || fin_abort) begin
        ack_q    <= grant_oh;
        rr_ptr   <= rr_n;
        result_q <= fin_ok ? bus.dp_sum : '0;
      end
    end
  end

`ifdef LIST_SUM_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_NODES + 1);

  logic [CNT_W-1:0] cnt;
  logic [NREQ-1:0]  err_q;
  logic             abort_q;

  // Fires on the step that brings the count to MAX_NODES.
  assign hit = bus.dp_step && (cnt == CNT_W'(MAX_NODES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      err_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      err_q   <= fin_abort ? grant_oh : '0;
      abort_q <= fin_abort;
      if (state == LAUNCH) cnt <= '0;
      else if (state == WAIT && bus.dp_step) cnt <= cnt + 1'b1;
    end
  end

  assign bus.err      = err_q;
  assign bus.dp_abort = abort_q;
`else
  logic unused_step;

  assign hit          = 1'b0;
  assign unused_step  = bus.dp_step ^ (MAX_NODES == 0);
  assign bus.err      = '0;
  assign bus.dp_abort = 1'b0;
`endif

  assign bus.ack      = ack_q;
  assign bus.result   = result_q;
  assign bus.grant_id = gid_q;
  assign bus.dp_head  = head_q;
  assign bus.busy     = (state != IDLE);
  assign bus.dp_start = (state == LAUNCH) || (state == WAIT);

endmodule

// File: doc/list_sum_arbiter.md
# list_sum_arbiter

Round-robin scheduler that shares the single linked-list-sum datapath and its FSM controller among `NREQ` requesters. Each requester presents a list head pointer and a request. The block latches one head, launches the walk through the controller's `start`/`done` handshake, and returns the captured sum with a one-cycle acknowledge. It sits between the requesting clients and the datapath/controller pair, and is the only driver of the controller's `start`.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `ADDR_W`, default 8: list pointer width.
- `DATA_W`, default 16: sum width.
- `MAX_NODES`, default 255: node limit used by the watchdog (see Configuration).

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  NREQ  per-requester request level.
- `head_ptr`  in  NREQ*ADDR_W  flattened heads; requester i occupies bits [i*ADDR_W +: ADDR_W].
- `ack`  out  NREQ  one-cycle completion pulse to the granted requester.
- `err`  out  NREQ  one-cycle pulse, coincident with `ack`, marking an aborted walk.
- `result`  out  DATA_W  sum of the last completed walk; held until the next completion.
- `busy`  out  1  high from ARB through RELEASE.
- `grant_id`  out  $clog2(NREQ)  index of the current or last granted requester.
- `dp_start`  out  1  drives the controller's `start`.
- `dp_head`  out  ADDR_W  latched head pointer to the datapath pointer mux.
- `dp_done`  in  1  controller `done`.
- `dp_sum`  in  DATA_W  datapath sum register.
- `dp_step`  in  1  pulses once per node visited; tied to the controller's `ld_next`.
- `dp_abort`  out  1  one-cycle pulse, OR'ed into the controller's and datapath's `rst`.

## Operation
- State machine states: IDLE, ARB, LAUNCH, WAIT, RELEASE.
- IDLE: if any `req` bit is high, go to ARB; otherwise stay in IDLE.
- ARB: pick the first set `req` bit at or after `rr_ptr`, wrapping modulo NREQ. Latch `grant_id` and `dp_head`, then go to LAUNCH.
  - If `req` has gone to zero during ARB, return to IDLE with no grant.
- LAUNCH: assert `dp_start` and go to WAIT.
- WAIT: hold `dp_start`=1. When `dp_done`=1:
  - capture `dp_sum` into `result`;
  - pulse `ack[grant_id]`;
  - set `rr_ptr` = (`grant_id`+1) mod NREQ;
  - go to RELEASE.
- RELEASE: hold `dp_start`=0 until `dp_done`=0, so the controller leaves its DONE state. Then go to IDLE.
- Requester rules:
  - A requester holds `req` until it sees `ack`.
  - If `req` drops after the grant, the walk still completes and `ack` still pulses.
  - A requester sees at most one `ack` per grant.
  - Re-arbitration starts only from IDLE, so there is no preemption.
- `result` is DATA_W wide and copied verbatim; overflow is the datapath's concern.

## Timing
- Reset values: `ack`=0, `err`=0, `result`=0, `busy`=0, `grant_id`=0, `dp_start`=0, `dp_head`=0, `dp_abort`=0, `rr_ptr`=0, state IDLE.
- `rst` asserted mid-walk returns the block to IDLE immediately. The controller shares `rst`, so both restart cleanly; no `ack` is produced.
- `req` to `dp_start` latency: 2 cycles (IDLE→ARB→LAUNCH).
- `dp_done` to `ack`: `ack` is registered and visible the cycle after `dp_done` is sampled high.
- Minimum spacing between back-to-back grants: RELEASE plus IDLE, i.e. at least 2 cycles after `ack`.
- Simultaneous requests are resolved by `rr_ptr` alone. Requests that arrive during a walk wait for IDLE.

## Configuration
- Macro: `LIST_SUM_TIMEOUT_EN`.
- With the macro defined:
  - A node counter clears in LAUNCH and increments on each `dp_step` in WAIT.
  - If the counter reaches `MAX_NODES` with `dp_done`=0, the block pulses `dp_abort`, sets `result`=0, pulses `ack` and `err` for the granted requester, advances `rr_ptr`, and goes to RELEASE.
  - This catches cyclic lists.
- Without the macro:
  - No counter is built.
  - `dp_abort` and `err` are tied to 0.
  - WAIT waits indefinitely for `dp_done`.

## Structure
- Shared package `list_sum_pkg` holds:
  - the state enum (IDLE, ARB, LAUNCH, WAIT, RELEASE);
  - default widths for `ADDR_W` and `DATA_W`.
- Sub-module `rr_picker`: combinational round-robin priority encoder taking `req` and `rr_ptr`, returning `valid` and `index`.

## Test plan
- Single requester: `req`=4'b0001, head 0x10, 3-node list summing to 0x0036 → `dp_start` 2 cycles after `req`, then `ack`=4'b0001, `result`=0x0036, `grant_id`=0.
- Contention: `req`=4'b1111 held, re-raised after each `ack` → grants in order 0,1,2,3,0, each `result` matching that requester's list.
- Fairness across gaps: from reset, `req`=4'b1010 → grant 1. Then `req`=4'b0011 → grant 0 (first set bit at or after `rr_ptr`=2, wrapping). `rr_ptr`=1 after the grant to 0.
- Handshake release: after `ack`, `dp_done` is held for 3 cycles → `dp_start` stays 0 and `busy`=1 until `dp_done`=0, then one IDLE cycle.
- Reset mid-walk: assert `rst` in WAIT → all outputs 0 in the same cycle, no `ack`. After release, a pending `req`=4'b0100 gets granted to 2.
- With `LIST_SUM_TIMEOUT_EN`, `MAX_NODES`=8, cyclic list → `dp_abort` pulse after the 8th `dp_step`, then `ack`+`err` on the requester with `result`=0. The next request completes normally.
